// File: rtl/fsic_pkg.sv
// Shared definitions for the FSIC IO-SERDES transmit arbiter: FSM encoding,
// tid width and the requester-index width helper.
package fsic_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int TID_W = 2;

    // Bits needed to hold a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsic_axis_skid2.sv
// Two-entry registered output stage between the arbiter and the serdes TX input.
// The caller only pushes when not full, unless a pop happens in the same cycle.
module fsic_axis_skid2 #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [PW-1:0] data_i,
    output logic          full_o,
    output logic          valid_o,
    input  logic          pop_ready_i,
    output logic [PW-1:0] data_o
);

    logic [PW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          pop;
    logic          push_ok;

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign data_o  = mem_q[rd_ptr_q];
    assign pop     = valid_o && pop_ready_i;
    assign push_ok = push_i && (!full_o || pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fsic_is_tx_arb.sv
// Packet-atomic round-robin arbiter sharing the serdes TX stream among
// pNUM_REQ AXI-Stream requesters; tid carries the granted requester index.
module fsic_is_tx_arb
    import fsic_pkg::*;
#(
    parameter int pNUM_REQ    = 4,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                              axis_clk,
    input  logic                              axis_rst_n,
    input  logic [pNUM_REQ*pDATA_WIDTH-1:0]   req_tdata,
    input  logic [pNUM_REQ*(pDATA_WIDTH/8)-1:0] req_tstrb,
    input  logic [pNUM_REQ*(pDATA_WIDTH/8)-1:0] req_tkeep,
    input  logic [pNUM_REQ*2-1:0]             req_tuser,
    input  logic [pNUM_REQ-1:0]               req_tlast,
    input  logic [pNUM_REQ-1:0]               req_tvalid,
    output logic [pNUM_REQ-1:0]               req_tready,
    output logic [pDATA_WIDTH-1:0]            as_is_tdata,
    output logic [pDATA_WIDTH/8-1:0]          as_is_tstrb,
    output logic [pDATA_WIDTH/8-1:0]          as_is_tkeep,
    output logic [TID_W-1:0]                  as_is_tid,
    output logic [1:0]                        as_is_tuser,
    output logic                              as_is_tlast,
    output logic                              as_is_tvalid,
    input  logic                              is_as_tready,
    input  logic                              arb_en,
    output logic                              arb_busy,
    output logic [TID_W-1:0]                  arb_grant,
    output arb_state_e                        dbg_state_o,
    output logic [TID_W-1:0]                  dbg_rr_ptr_o
);

    localparam int SW    = pDATA_WIDTH / 8;
    localparam int IDX_W = idx_width(pNUM_REQ);
    localparam int PW    = pDATA_WIDTH + 2 * SW + 2 + TID_W + 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [pDATA_WIDTH-1:0] r_data [pNUM_REQ];
    logic [SW-1:0]          r_strb [pNUM_REQ];
    logic [SW-1:0]          r_keep [pNUM_REQ];
    logic [1:0]             r_user [pNUM_REQ];

    for (genvar k = 0; k < pNUM_REQ; k++) begin : g_unpack
        assign r_data[k] = req_tdata[k*pDATA_WIDTH +: pDATA_WIDTH];
        assign r_strb[k] = req_tstrb[k*SW +: SW];
        assign r_keep[k] = req_tkeep[k*SW +: SW];
        assign r_user[k] = req_tuser[k*2 +: 2];
    end

    logic [IDX_W-1:0]    rr_next;
    logic [IDX_W-1:0]    search_base;
    logic [IDX_W-1:0]    cand;
    logic [pNUM_REQ-1:0] search_vld;
    logic                found;
    logic [IDX_W-1:0]    win;
    logic                stage_full;
    logic                stage_valid;
    logic                accept;
    logic                eop;
    logic [TID_W-1:0]    tid_w;
    logic [PW-1:0]       in_pay;
    logic [PW-1:0]       out_pay;

    assign rr_next = (grant_q == IDX_W'(pNUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // While granted, the search looks at the other requesters from the
    // post-packet pointer so a back-to-back handover costs no idle cycle.
    always_comb begin
        search_vld  = req_tvalid;
        search_base = rr_ptr_q;
        if (state_q == ST_GRANT) begin
            search_vld[grant_q] = 1'b0;
            search_base         = rr_next;
        end
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < pNUM_REQ; i++) begin
            cand = IDX_W'((int'(search_base) + i) % pNUM_REQ);
            if (!found && search_vld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // A beat moves on valid && ready; ready to the owner depends only on
    // output-stage space, never on the owner's own valid.
    assign accept = (state_q == ST_GRANT) && req_tvalid[grant_q] && !stage_full;
    assign eop    = accept && req_tlast[grant_q];

    always_comb begin
        req_tready = '0;
        if (state_q == ST_GRANT && !stage_full) begin
            req_tready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && found) begin
                    state_d = ST_GRANT;
                    grant_d = win;
                end
            end
            ST_GRANT: begin
                if (eop) begin
                    rr_ptr_d = rr_next;
                    if (arb_en && found) begin
                        grant_d = win;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign tid_w  = TID_W'(grant_q);
    assign in_pay = {r_data[grant_q], r_strb[grant_q], r_keep[grant_q],
                     r_user[grant_q], tid_w, req_tlast[grant_q]};

    fsic_axis_skid2 #(
        .PW(PW)
    ) u_skid (
        .clk_i       (axis_clk),
        .rst_n_i     (axis_rst_n),
        .push_i      (accept),
        .data_i      (in_pay),
        .full_o      (stage_full),
        .valid_o     (stage_valid),
        .pop_ready_i (is_as_tready),
        .data_o      (out_pay)
    );

    assign {as_is_tdata, as_is_tstrb, as_is_tkeep, as_is_tuser, as_is_tid, as_is_tlast} = out_pay;
    assign as_is_tvalid = stage_valid;
    assign arb_busy     = (state_q == ST_GRANT) || stage_valid;
    assign arb_grant    = tid_w;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = TID_W'(rr_ptr_q);

endmodule
